// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads a block of RAM over the shared memory bus and streams
// each byte out as an 8N1 UART frame (LSB first, line idles high).
// Handshake: start is a one-cycle request accepted only in IDLE when abort
// is low; busy marks bus ownership, done pulses once per completed dump.
// Every output, including the debug view of the FSM state, is a register.
module mem_dump_tx #(
   parameter int ADDR_W  = 16,
   parameter int RD_LAT  = 2,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic [7:0]        data_in,
   output logic [ADDR_W-1:0] addr,
   output logic              read,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [3:0]  LAT_LAST  = 4'(RD_LAT - 1);
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   state_t state, state_next;

   logic [3:0]        lat_cnt, lat_cnt_next;
   logic [15:0]       baud_cnt, baud_cnt_next;
   logic [2:0]        bit_cnt, bit_cnt_next;
   logic [7:0]        shift, shift_next;
   logic [ADDR_W-1:0] remaining, remaining_next;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W-1:0] rem_dec;
   logic              read_next, tx_next, busy_next, done_next;
   logic              accept, lat_end, bit_end, kill;

   // abort wins over start in IDLE, and cancels any active dump
   assign accept  = start & ~abort;
   assign kill    = abort & (state != S_IDLE);
   assign lat_end = (lat_cnt == LAT_LAST);
   assign bit_end = (baud_cnt == BAUD_LAST);
   assign rem_dec = remaining - ADDR_W'(1);

   assign state_dbg = state;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // next-state logic: one read phase then a 10-bit frame per byte
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = (length != '0) ? S_REQ : S_FIN;
         S_REQ:   if (lat_end) state_next = S_START;
         S_START: if (bit_end) state_next = S_DATA;
         S_DATA:  if (bit_end && bit_cnt == 3'd7) state_next = S_STOP;
         S_STOP:  if (bit_end) state_next = (rem_dec != '0) ? S_REQ : S_FIN;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (kill) state_next = S_IDLE;
   end

   // datapath next values: address, byte count, shifter and counters
   always_comb begin
      addr_next      = addr;
      remaining_next = remaining;
      shift_next     = shift;
      lat_cnt_next   = '0;
      baud_cnt_next  = '0;
      bit_cnt_next   = '0;
      case (state)
         S_IDLE: begin
            if (accept && length != '0) begin
               addr_next      = start_addr;
               remaining_next = length;
            end
         end
         S_REQ: begin
            lat_cnt_next = lat_end ? 4'd0 : lat_cnt + 4'd1;
            // the RAM data is valid on the last cycle of the read phase
            if (lat_end) shift_next = data_in;
         end
         S_START: begin
            baud_cnt_next = bit_end ? 16'd0 : baud_cnt + 16'd1;
         end
         S_DATA: begin
            baud_cnt_next = bit_end ? 16'd0 : baud_cnt + 16'd1;
            bit_cnt_next  = bit_cnt;
            if (bit_end) begin
               bit_cnt_next = bit_cnt + 3'd1;
               shift_next   = {1'b0, shift[7:1]};
            end
         end
         S_STOP: begin
            baud_cnt_next = bit_end ? 16'd0 : baud_cnt + 16'd1;
            if (bit_end) begin
               remaining_next = rem_dec;
               // address wraps naturally at 2^ADDR_W
               if (rem_dec != '0) addr_next = addr + ADDR_W'(1);
            end
         end
         default: ;
      endcase
      if (kill) begin
         lat_cnt_next  = '0;
         baud_cnt_next = '0;
         bit_cnt_next  = '0;
      end
   end

   // output next values derived from the state being entered, so the
   // registered outputs line up exactly with the state they describe
   always_comb begin
      read_next = (state_next == S_REQ);
      busy_next = (state_next == S_REQ) || (state_next == S_START) ||
                  (state_next == S_DATA) || (state_next == S_STOP);
      done_next = (state_next == S_FIN);
      case (state_next)
         S_START: tx_next = 1'b0;
         S_DATA:  tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         remaining <= '0;
         shift     <= '0;
         lat_cnt   <= '0;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         read      <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         addr      <= addr_next;
         remaining <= remaining_next;
         shift     <= shift_next;
         lat_cnt   <= lat_cnt_next;
         baud_cnt  <= baud_cnt_next;
         bit_cnt   <= bit_cnt_next;
         read      <= read_next;
         tx        <= tx_next;
         busy      <= busy_next;
         done      <= done_next;
      end
   end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Testbench for mem_dump_tx: random and directed dumps from a behavioural
// RAM; expected bytes, read addresses and completion times are queued when
// a dump is issued and consumed by independent monitors.
module tb_mem_dump_tx;

   localparam int RD_LAT  = 2;
   localparam int CLK_DIV = 4;
   localparam int PERIOD  = RD_LAT + 10 * CLK_DIV;
   localparam int FRAME   = 10 * CLK_DIV;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort;
   logic [15:0] start_addr, length;
   logic [7:0]  data_in;
   logic [15:0] addr;
   logic        read, tx, busy, done;
   logic [2:0]  state_dbg;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_dump_tx #(.ADDR_W(16), .RD_LAT(RD_LAT), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .start_addr(start_addr), .length(length), .data_in(data_in),
      .addr(addr), .read(read), .tx(tx), .busy(busy), .done(done),
      .state_dbg(state_dbg)
   );

   // behavioural RAM with one register stage (data valid RD_LAT=2 cycles
   // after the read strobe first appears)
   logic [7:0] mem [0:65535];
   logic [7:0] ram_q;
   always @(posedge clk) ram_q <= mem[addr];
   assign data_in = ram_q;

   // ---------------- scoreboard ----------------
   logic [7:0]  exp_q[$];
   logic [15:0] exp_addr_q[$];
   int          exp_done_q[$];
   int          exp_busy_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   task automatic flush_queues();
      exp_q.delete();
      exp_addr_q.delete();
      exp_done_q.delete();
      exp_busy_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_dump(input logic [15:0] sa, input logic [15:0] len);
      logic [15:0] a;
      @(negedge clk);
      for (int i = 0; i < int'(len); i++) begin
         a = sa + 16'(i);
         exp_q.push_back(mem[a]);
         exp_addr_q.push_back(a);
      end
      exp_done_q.push_back(cyc + 1 + int'(len) * PERIOD);
      if (len != 16'd0) exp_busy_q.push_back(int'(len) * PERIOD);
      start_addr = sa;
      length     = len;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      start_addr = 16'($urandom);
      length     = 16'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy === 1'b1 || done === 1'b1 || exp_done_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_timeout", 32'(n >= budget), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // ---------------- monitors ----------------
   // UART receiver: checks every bit-cycle of a frame against the queued byte
   initial begin : rx_mon
      logic [FRAME-1:0] act, expv;
      logic [7:0]       eb, gb;
      bit               ok, have;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && busy === 1'b1 && tx === 1'b0) begin
            have = (exp_q.size() != 0);
            eb   = have ? exp_q[0] : 8'h00;
            for (int k = 0; k < FRAME; k++) expv[k] = frame_bit(eb, k / CLK_DIV);
            act    = '0;
            act[0] = tx;
            ok     = 1'b1;
            for (int k = 1; k < FRAME; k++) begin
               @(negedge clk);
               if (busy !== 1'b1 || rst !== 1'b1) begin
                  ok = 1'b0;
                  break;
               end
               act[k] = tx;
            end
            if (ok) begin
               for (int i = 0; i < 8; i++) gb[i] = act[(i + 1) * CLK_DIV + CLK_DIV / 2];
               checks++;
               if (!have) begin
                  errors++;
                  $display("FAIL unexpected_frame: got byte %02h expected no frame", gb);
               end else begin
                  void'(exp_q.pop_front());
                  if (act !== expv) begin
                     errors++;
                     $display("FAIL frame: got byte %02h samples %h expected byte %02h samples %h",
                              gb, act, eb, expv);
                  end
               end
            end
         end
      end
   end

   // line may only go low while a dump owns the bus
   always @(negedge clk) begin
      if (rst === 1'b1 && tx !== 1'b1) check("tx_low_while_idle", 32'(busy), 32'd1);
   end

   // read strobe: address at each new read, and strobe width
   initial begin : rd_mon
      logic        prev;
      int          run;
      logic [15:0] ea;
      prev = 1'b0;
      run  = 0;
      forever begin
         @(negedge clk);
         if (read === 1'b1 && !prev) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got addr %04h expected no read", addr);
            end else begin
               ea = exp_addr_q.pop_front();
               check("read_addr", 32'(addr), 32'(ea));
            end
            run = 1;
         end else if (read === 1'b1) begin
            run++;
         end else if (prev && busy === 1'b1) begin
            check("read_len", 32'(run), 32'(RD_LAT));
         end
         prev = (read === 1'b1);
      end
   end

   // done pulse: timing, width, and busy already low
   initial begin : done_mon
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            check("done_busy_low", 32'(busy), 32'd0);
            if (prev) begin
               checks++;
               errors++;
               $display("FAIL done_width: got second done cycle at %0d expected one cycle", cyc);
            end else if (exp_done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
               check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
            end
         end
         prev = (done === 1'b1);
      end
   end

   // busy duration of completed dumps
   initial begin : busy_mon
      logic prev;
      int   rise;
      prev = 1'b0;
      rise = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && !prev) rise = cyc;
         if (busy !== 1'b1 && prev && done === 1'b1) begin
            if (exp_busy_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_busy: got %0d busy cycles expected none", cyc - rise);
            end else begin
               check("busy_len", 32'(cyc - rise), 32'(exp_busy_q.pop_front()));
            end
         end
         prev = (busy === 1'b1);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [15:0] sa, len;
      start = 1'b0; abort = 1'b0; start_addr = '0; length = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0010] = 8'hA5;
      mem[16'h0020] = 8'h01;
      mem[16'h0021] = 8'h02;
      mem[16'h0022] = 8'h03;

      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_read", 32'(read), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_addr", 32'(addr), 32'd0);
      rst = 1'b1;

      // single byte, three back-to-back bytes, address wrap, empty dump
      start_dump(16'h0010, 16'd1);  wait_idle(300);
      start_dump(16'h0020, 16'd3);  wait_idle(500);
      start_dump(16'hFFFF, 16'd2);  wait_idle(300);
      start_dump(16'h0040, 16'd0);
      check("len0_busy", 32'(busy), 32'd0);
      wait_idle(50);

      // abort together with start in IDLE: start must be ignored
      @(negedge clk);
      start_addr = 16'h0050; length = 16'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 32'(busy), 32'd0);
      check("abort_start_read", 32'(read), 32'd0);
      repeat (5) @(negedge clk);

      // abort during the data bits of the first of four bytes
      start_dump(16'h0100, 16'd4);
      repeat (RD_LAT + CLK_DIV + 10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_read", 32'(read), 32'd0);
      flush_queues();
      repeat (60) @(negedge clk);
      start_dump(16'h0180, 16'd1);  wait_idle(300);

      // start while busy is ignored
      start_dump(16'h0200, 16'd2);
      repeat (20) @(negedge clk);
      start_addr = 16'h0300; length = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_addr", 32'(addr), 32'h0200);
      wait_idle(400);

      // asynchronous reset in the middle of a frame
      start_dump(16'h0400, 16'd3);
      repeat (60) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset_tx", 32'(tx), 32'd1);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_addr", 32'(addr), 32'd0);
      check("midreset_read", 32'(read), 32'd0);
      flush_queues();
      @(negedge clk);
      rst = 1'b1;
      start_dump(16'h0500, 16'd2);  wait_idle(300);

      // random dumps, some near the top of the address space
      for (int t = 0; t < 12; t++) begin
         if ($urandom_range(0, 3) == 0) sa = 16'hFFFF - 16'($urandom_range(0, 2));
         else                           sa = 16'($urandom);
         len = 16'($urandom_range(0, 4));
         start_dump(sa, len);
         wait_idle(1000);
      end

      check("end_exp_q", 32'(exp_q.size()), 32'd0);
      check("end_addr_q", 32'(exp_addr_q.size()), 32'd0);
      check("end_done_q", 32'(exp_done_q.size()), 32'd0);
      check("end_busy_q", 32'(exp_busy_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- Memory-bus reader that streams a block of RAM contents out of the board over a serial UART transmit line, giving the host a readback of program and data memory.
- Sits beside the cpu as a second bus initiator on the ram's read port: addr, read strobe, 8-bit data returned on rambus.
- The top level muxes its addr/read onto the ram only while busy=1 and the CPU is halted.
- Complements the switch-based D/A1 loading path: that path writes memory, this block reads it out.

Parameters:
- ADDR_W, 16, memory address width (matches addr bus).
- RD_LAT, 2, clk cycles from read assertion to valid data_in (covers clk_mem phase); legal 1..15.
- CLK_DIV, 4, clk cycles per serial bit (simulation value; synthesis sets baud divisor); legal 2..65535.

Ports:
- clk, input, 1, block clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a dump when idle.
- abort, input, 1, level; cancels a dump in progress.
- start_addr, input, ADDR_W, first address to read.
- length, input, ADDR_W, number of bytes to send.
- data_in, input, 8, ram read data (rambus).
- addr, output, ADDR_W, ram address.
- read, output, 1, ram read strobe.
- tx, output, 1, UART line, idle high, 8N1, LSB first.
- busy, output, 1, dump in progress (bus owned).
- done, output, 1, one-cycle pulse at completion.

Behaviour:
- Reset (rst=0, async): state IDLE; addr=0, read=0, tx=1, busy=0, done=0; shift register, bit counter, baud counter and remaining count all cleared.
- Sampling: start_addr and length are sampled on the cycle start=1 in IDLE.
- start ignored: start is ignored while busy=1.
- States: IDLE, REQ, START, DATA, STOP, FIN.
- IDLE -> REQ: on start with length!=0. The accepted cycle captures addr=start_addr and remaining=length. busy=1 from the next cycle.
- IDLE -> FIN: on start with length==0. done pulses the next cycle; no read is issued and tx stays high.
- REQ: read=1 and addr held for exactly RD_LAT cycles. On the last REQ cycle data_in is latched into the shift register. -> START.
- START: tx=0 for CLK_DIV cycles. read=0 from the first START cycle onward. -> DATA.
- DATA: tx=shift[0] for CLK_DIV cycles per bit, shifting right, 8 bits. -> STOP.
- STOP: tx=1 for CLK_DIV cycles; remaining decrements on the last STOP cycle.
  - remaining (after decrement) != 0: addr increments and the block goes back to REQ.
  - remaining == 0: go to FIN.
- FIN: done=1 for one cycle, busy=0 in that same cycle, -> IDLE. addr holds its last value.
- Per-byte period: RD_LAT + 10*CLK_DIV cycles, with no idle gap between frames.
- Address wrap: addr increments modulo 2^ADDR_W (0xFFFF -> 0x0000).
- abort=1 in any non-IDLE state: next cycle state=IDLE, read=0, tx=1 (a truncated frame is acceptable), busy=0, done NOT pulsed.
- abort vs start: abort=1 together with start in IDLE means start is ignored.
- Baud counter: counts 0..CLK_DIV-1 within each bit and restarts at every bit boundary.
- Registered outputs: all outputs are driven from registers, with no combinational path from inputs to outputs.
- tx is glitch-free.
- Reset mid-dump: behaves as the reset case above; the next start begins cleanly.

Test Plan:
- Single byte: data_in=0xA5, start_addr=0x0010, length=1, defaults.
  - read=1 with addr=0x0010 for 2 cycles.
  - tx then shows 0 (4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk).
  - done pulses once; busy high for 42 cycles total.
- Three bytes from 0x0020 with mem = 0x01, 0x02, 0x03:
  - three back-to-back frames decode to 01, 02, 03.
  - addr steps 0x20, 0x21, 0x22.
  - done exactly once, 126 cycles after busy rises.
- Wrap: start_addr=0xFFFF, length=2 -> reads at 0xFFFF then 0x0000, and two frames are sent.
- length=0 -> no read pulse, tx constant 1, done pulses one cycle after start, busy never asserts.
- abort during DATA of byte 1 of 4 -> next cycle tx=1, busy=0, read=0, no done. A later start with length=1 sends a correct frame.
- start while busy, and rst pulsed low mid-frame:
  - the second start has no effect on addr or length.
  - rst forces tx=1, busy=0, addr=0 asynchronously.
